// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------
// riscv_pkg : shared core constants and fetch-buffer slot type
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam int          FB_DEPTH  = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fb_slot_t;

endpackage

`default_nettype wire

// File: rtl/fetch_slot_array.sv
// ----------------------------------------------------------------
// fetch_slot_array : slot storage with alloc/fill/read ring pointers
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module fetch_slot_array
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = FB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_alloc,
  input  logic [WIDTH-1:0]           i_alloc_pc,
  input  logic                       i_fill,
  input  logic [WIDTH-1:0]           i_fill_data,
  input  logic                       i_pop,
  output logic                       o_head_valid,
  output logic [WIDTH-1:0]           o_head_pc,
  output logic [WIDTH-1:0]           o_head_instr,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fb_slot_t           r_slot [DEPTH];
  logic [DEPTH-1:0]   r_alloc;
  logic [PTR_W-1:0]   r_alloc_ptr;
  logic [PTR_W-1:0]   r_fill_ptr;
  logic [PTR_W-1:0]   r_read_ptr;
  logic [CNT_W-1:0]   r_count;
  fb_slot_t           w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alloc     <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_read_ptr  <= '0;
      r_count     <= '0;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
    end else if (i_clear) begin
      r_alloc     <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_read_ptr  <= '0;
      r_count     <= '0;
      for (int i = 0; i < DEPTH; i++) r_slot[i].filled <= 1'b0;
    end else begin
      // alloc, fill and pop always address distinct slots, so their writes never collide
      for (int i = 0; i < DEPTH; i++) begin
        if (i_alloc && r_alloc_ptr == PTR_W'(i)) begin
          r_alloc[i]       <= 1'b1;
          r_slot[i].pc     <= XLEN'(i_alloc_pc);
          r_slot[i].filled <= 1'b0;
        end
        if (i_fill && r_fill_ptr == PTR_W'(i)) begin
          r_slot[i].instr  <= XLEN'(i_fill_data);
          r_slot[i].filled <= 1'b1;
        end
        if (i_pop && r_read_ptr == PTR_W'(i)) begin
          r_alloc[i]       <= 1'b0;
          r_slot[i].filled <= 1'b0;
        end
      end
      if (i_alloc) r_alloc_ptr <= r_alloc_ptr + PTR_W'(1);
      if (i_fill)  r_fill_ptr  <= r_fill_ptr + PTR_W'(1);
      if (i_pop)   r_read_ptr  <= r_read_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_alloc) - CNT_W'(i_pop);
    end
  end

  assign w_head       = r_slot[r_read_ptr];
  assign o_head_valid = r_alloc[r_read_ptr] & w_head.filled;
  assign o_head_pc    = WIDTH'(w_head.pc);
  assign o_head_instr = WIDTH'(w_head.instr);
  assign o_count      = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------
// fetch_buffer : decouples instruction memory responses from decode
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = FB_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_i,
  output logic             pc_ready_o,
  input  logic             flush_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [WIDTH-1:0] dec_instr_o,
  output logic [WIDTH-1:0] dec_pc_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] r_outst;
  logic [CNT_W-1:0] r_drop;
  logic [WIDTH-1:0] r_last_pc;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occ;
  logic [CNT_W:0]   w_pend;
  logic [CNT_W:0]   w_flush_drop;
  logic             w_req;
  logic             w_grant;
  logic             w_fill;
  logic             w_pop;
  logic             w_head_valid;
  logic [WIDTH-1:0] w_head_pc;
  logic [WIDTH-1:0] w_head_instr;

  // Stale responses still owed by memory count against capacity until they drain
  assign w_occ   = {1'b0, w_count} + {1'b0, r_drop};
  assign w_req   = !rst && !flush_i && (w_occ < (CNT_W+1)'(DEPTH));
  assign w_grant = w_req & imem_gnt_i;
  assign w_fill  = imem_rvalid_i && !flush_i && (r_drop == '0) && (r_outst != '0);
  assign w_pop   = w_head_valid & dec_ready_i & !flush_i;

  // Oldest responses belong to the drop group, so a coincident rvalid retires one of them
  assign w_pend       = {1'b0, r_drop} + {1'b0, r_outst};
  assign w_flush_drop = (imem_rvalid_i && w_pend != '0) ? w_pend - (CNT_W+1)'(1) : w_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outst   <= '0;
      r_drop    <= '0;
      r_last_pc <= '0;
    end else begin
      if (w_head_valid) r_last_pc <= w_head_pc;
      if (flush_i) begin
        r_outst <= '0;
        r_drop  <= CNT_W'(w_flush_drop);
      end else begin
        r_outst <= r_outst + CNT_W'(w_grant) - CNT_W'(w_fill);
        if (imem_rvalid_i && r_drop != '0) r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  fetch_slot_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_slots (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (flush_i),
    .i_alloc      (w_grant),
    .i_alloc_pc   (pc_i),
    .i_fill       (w_fill),
    .i_fill_data  (imem_rdata_i),
    .i_pop        (w_pop),
    .o_head_valid (w_head_valid),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr),
    .o_count      (w_count)
  );

  assign imem_req_o  = w_req;
  assign imem_addr_o = pc_i;
  assign pc_ready_o  = w_grant;
  assign dec_valid_o = w_head_valid;
  assign dec_instr_o = w_head_valid ? w_head_instr : WIDTH'(NOP_INSTR);
  assign dec_pc_o    = w_head_valid ? w_head_pc : r_last_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ----------------------------------------------------------------
// tb_fetch_buffer : directed and randomized checks of fetch_buffer
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_fetch_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: program-order list of fetches the decoder should see, and memory's pending queue
  logic [31:0] exp_pc_q[$];
  bit          exp_ret_q[$];
  logic [31:0] mem_q[$];
  bit          mem_stale_q[$];
  logic [31:0] tb_pc, last_pc, redirect_pc;

  always #5 clk = ~clk;

  fetch_buffer #(.WIDTH(32), .DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_ready_o    (pc_ready_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_instr_o   (dec_instr_o),
    .dec_pc_o      (dec_pc_o)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F_0F0F;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_stale_q[i]) if (mem_stale_q[i]) n++;
    return n;
  endfunction

  function automatic bit m_req();
    return !flush_i && ((exp_pc_q.size() + stale_cnt()) < D);
  endfunction

  function automatic bit m_valid();
    return (exp_pc_q.size() > 0) && exp_ret_q[0];
  endfunction

  task automatic apply_reset();
    rst = 1'b1; flush_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = '0; dec_ready_i = 1'b0; pc_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc_q.delete(); exp_ret_q.delete(); mem_q.delete(); mem_stale_q.delete();
    tb_pc = '0; last_pc = '0; redirect_pc = '0;
  endtask

  // rvm: 0 = no response, 1 = return oldest pending if any, 2 = as 1 but spurious rvalid when none pending
  task automatic drive(input bit f, input bit g, input int rvm, input bit rdy);
    @(negedge clk);
    flush_i = f; imem_gnt_i = g; dec_ready_i = rdy; pc_i = tb_pc;
    if (rvm != 0 && mem_q.size() > 0) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = instr_of(mem_q[0]);
    end else if (rvm == 2) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = $urandom;
    end else begin
      imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
    end
    #1;
  endtask

  task automatic advance();
    bit          req, v, grant, pop, rv_real, f, s;
    logic [31:0] gpc;
    req = m_req(); v = m_valid(); f = flush_i;
    grant = req & imem_gnt_i;
    pop = v & dec_ready_i & !f;
    rv_real = imem_rvalid_i && (mem_q.size() > 0);
    gpc = tb_pc;
    if (v) last_pc = exp_pc_q[0];
    @(posedge clk);
    if (rv_real) begin
      s = mem_stale_q.pop_front();
      void'(mem_q.pop_front());
      if (!s && !f) begin
        for (int i = 0; i < exp_ret_q.size(); i++)
          if (!exp_ret_q[i]) begin exp_ret_q[i] = 1'b1; break; end
      end
    end
    if (pop) begin void'(exp_pc_q.pop_front()); void'(exp_ret_q.pop_front()); end
    if (f) begin
      exp_pc_q.delete(); exp_ret_q.delete();
      foreach (mem_stale_q[i]) mem_stale_q[i] = 1'b1;
      tb_pc = redirect_pc;
    end
    if (grant) begin
      exp_pc_q.push_back(gpc); exp_ret_q.push_back(1'b0);
      mem_q.push_back(gpc); mem_stale_q.push_back(1'b0);
      tb_pc = gpc + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
    imem_rdata_i = '0; dec_ready_i = 1'b1; pc_i = 32'h40;
    #2;
    n_checks += 4;
    if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    if (pc_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_pc_ready: got %b expected 0", pc_ready_o); end
    if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dec_valid_o); end
    if (dec_instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000013", dec_instr_o); end
    apply_reset();
    n_checks++;
    if (dec_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", dec_pc_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] epc;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, k < 3, 1, 1'b1);
      if (k == 0) begin
        n_checks += 3;
        if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL b2b_req: got %b expected 1", imem_req_o); end
        if (pc_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_pc_ready: got %b expected 1", pc_ready_o); end
        if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL b2b_addr: got %h expected 0", imem_addr_o); end
      end
      epc = (k >= 2 && k <= 4) ? 32'(4 * (k - 2)) : 32'h8;
      n_checks += 3;
      if (dec_valid_o !== (k >= 2 && k <= 4)) begin
        n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, dec_valid_o, (k >= 2 && k <= 4));
      end
      if (k >= 2 && dec_pc_o !== epc) begin
        n_fail++; $display("FAIL b2b_pc[%0d]: got %h expected %h", k, dec_pc_o, epc);
      end
      if (k >= 2 && dec_instr_o !== ((k <= 4) ? instr_of(epc) : 32'h0000_0013)) begin
        n_fail++; $display("FAIL b2b_instr[%0d]: got %h expected %h", k, dec_instr_o,
                           (k <= 4) ? instr_of(epc) : 32'h0000_0013);
      end
      advance();
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1, 1'b0);
      n_checks++;
      if (imem_req_o !== (k < 4)) begin n_fail++; $display("FAIL full_req[%0d]: got %b expected %b", k, imem_req_o, (k < 4)); end
      advance();
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    n_checks += 2;
    if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req_idle: got %b expected 0", imem_req_o); end
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0) begin
      n_fail++; $display("FAIL full_head: got valid=%b pc=%h expected valid=1 pc=0", dec_valid_o, dec_pc_o);
    end
    advance();
    drive(1'b0, 1'b1, 0, 1'b1);
    n_checks += 2;
    if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req_on_pop: got %b expected 0", imem_req_o); end
    if (pc_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_pc_ready_on_pop: got %b expected 0", pc_ready_o); end
    advance();
    drive(1'b0, 1'b1, 0, 1'b0);
    n_checks += 2;
    if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL full_req_after_pop: got %b expected 1", imem_req_o); end
    if (dec_pc_o !== 32'h4) begin n_fail++; $display("FAIL full_next_pc: got %h expected 4", dec_pc_o); end
    advance();
  endtask

  task automatic test_flush();
    apply_reset();
    drive(1'b0, 1'b1, 0, 1'b1); advance();
    drive(1'b0, 1'b1, 0, 1'b1); advance();
    redirect_pc = 32'h100;
    drive(1'b1, 1'b1, 0, 1'b1);
    n_checks += 2;
    if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_req: got %b expected 0", imem_req_o); end
    if (pc_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_pc_ready: got %b expected 0", pc_ready_o); end
    advance();
    drive(1'b0, 1'b1, 1, 1'b1);
    n_checks += 2;
    if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL flush_req_after: got %b expected 1", imem_req_o); end
    if (imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL flush_addr: got %h expected 100", imem_addr_o); end
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1, 1'b1);
      n_checks++;
      if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_stale_shown[%0d]: got %b expected 0", k, dec_valid_o); end
      advance();
    end
    drive(1'b0, 1'b0, 0, 1'b1);
    n_checks++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h100 || dec_instr_o !== instr_of(32'h100)) begin
      n_fail++; $display("FAIL flush_first: got valid=%b pc=%h instr=%h expected valid=1 pc=100 instr=%h",
                         dec_valid_o, dec_pc_o, dec_instr_o, instr_of(32'h100));
    end
    advance();
  endtask

  task automatic test_flush_rvalid();
    apply_reset();
    drive(1'b0, 1'b1, 0, 1'b1); advance();
    drive(1'b0, 1'b1, 0, 1'b1); advance();
    redirect_pc = 32'h200;
    drive(1'b1, 1'b0, 1, 1'b1); advance();
    drive(1'b0, 1'b1, 1, 1'b1);
    n_checks += 2;
    if (imem_addr_o !== 32'h200 || pc_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flrv_grant: got addr=%h ready=%b expected addr=200 ready=1", imem_addr_o, pc_ready_o);
    end
    if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flrv_valid0: got %b expected 0", dec_valid_o); end
    advance();
    drive(1'b0, 1'b0, 1, 1'b1);
    n_checks++;
    if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flrv_stale_shown: got %b expected 0", dec_valid_o); end
    advance();
    drive(1'b0, 1'b0, 0, 1'b1);
    n_checks++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h200) begin
      n_fail++; $display("FAIL flrv_first: got valid=%b pc=%h expected valid=1 pc=200", dec_valid_o, dec_pc_o);
    end
    advance();
  endtask

  task automatic test_stall();
    apply_reset();
    drive(1'b0, 1'b1, 1, 1'b0); advance();
    drive(1'b0, 1'b1, 1, 1'b0); advance();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1, 1'b0);
      n_checks++;
      if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0 || dec_instr_o !== instr_of(32'h0)) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h expected valid=1 pc=0 instr=%h",
                           k, dec_valid_o, dec_pc_o, dec_instr_o, instr_of(32'h0));
      end
      advance();
    end
    drive(1'b0, 1'b0, 0, 1'b1); advance();
    drive(1'b0, 1'b0, 0, 1'b1);
    n_checks++;
    if (dec_pc_o !== 32'h4) begin n_fail++; $display("FAIL stall_release: got %h expected 4", dec_pc_o); end
    advance();
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < 4; k++) begin drive(1'b0, k < 3, 1, 1'b0); advance(); end
    drive(1'b0, 1'b1, 0, 1'b0);
    n_checks++;
    if (dec_valid_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b expected 1", dec_valid_o); end
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", dec_valid_o); end
    if (dec_instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL areset_instr: got %h expected 00000013", dec_instr_o); end
    if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL areset_req: got %b expected 0", imem_req_o); end
    if (pc_ready_o !== 1'b0) begin n_fail++; $display("FAIL areset_pc_ready: got %b expected 0", pc_ready_o); end
    if (dec_pc_o !== 32'h0) begin n_fail++; $display("FAIL areset_pc: got %h expected 0", dec_pc_o); end
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      bit          f, g, rdy, e_req, e_v;
      int          rvm, r;
      logic [31:0] e_pc, e_instr;
      f   = ($urandom_range(0, 99) < 5);
      g   = ($urandom_range(0, 99) < 65);
      rdy = ($urandom_range(0, 99) < 60);
      r   = $urandom_range(0, 9);
      rvm = (r < 6) ? 1 : ((r < 7) ? 2 : 0);
      if (f) redirect_pc = {14'h0, 16'($urandom), 2'b00};
      drive(f, g, rvm, rdy);
      e_req   = m_req();
      e_v     = m_valid();
      e_pc    = e_v ? exp_pc_q[0] : last_pc;
      e_instr = e_v ? instr_of(exp_pc_q[0]) : 32'h0000_0013;
      n_checks += 6;
      if (imem_req_o !== e_req) begin n_fail++; $display("FAIL rnd_req@%0d: got %b expected %b", c, imem_req_o, e_req); end
      if (pc_ready_o !== (e_req & g)) begin n_fail++; $display("FAIL rnd_pc_ready@%0d: got %b expected %b", c, pc_ready_o, e_req & g); end
      if (imem_addr_o !== tb_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h expected %h", c, imem_addr_o, tb_pc); end
      if (dec_valid_o !== e_v) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, dec_valid_o, e_v); end
      if (dec_pc_o !== e_pc) begin n_fail++; $display("FAIL rnd_pc@%0d: got %h expected %h", c, dec_pc_o, e_pc); end
      if (dec_instr_o !== e_instr) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h expected %h", c, dec_instr_o, e_instr); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_flush();
    test_flush_rvalid();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
